// File: rtl/mic_pkg.sv
// Shared types and defaults for the microphone capture sequencer.
package mic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned DefDivW    = 8;
  localparam int unsigned DefDecim   = 64;
  localparam int unsigned DefSampleW = 16;
  localparam int unsigned DefCntW    = 16;

  // Popcount must hold 0..decim inclusive.
  function automatic int unsigned pop_width(input int unsigned decim);
    return $clog2(decim) + 1;
  endfunction

endpackage

// File: rtl/mic_pdm_clkgen.sv
// PDM clock divider: half-period of (div+1) cycles, strobe on each falling edge.
module mic_pdm_clkgen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             pdm_clk,
  output logic             bit_strobe
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    bit_strobe = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (cnt_q == div) begin
      cnt_d      = '0;
      clk_d      = ~clk_q;
      bit_strobe = clk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Gated so the clock drops in the same cycle the sequencer leaves RUN.
  assign pdm_clk = clk_q & enable;

endmodule

// File: rtl/mic_capture_ctrl.sv
// Capture sequencer: drives the PDM clock, decimates PDM bits into signed PCM samples
// and presents them on a one-entry valid/ready output register.
module mic_capture_ctrl
  import mic_pkg::*;
#(
  parameter int unsigned DIV_W    = DefDivW,
  parameter int unsigned DECIM    = DefDecim,
  parameter int unsigned SAMPLE_W = DefSampleW,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic [DIV_W-1:0]    cfg_clk_div,
  input  logic [CNT_W-1:0]    cfg_num_samples,
  output logic                pdm_clk,
  output logic                pdm_lrsel,
  input  logic                pdm_data,
  output logic [SAMPLE_W-1:0] smp_tdata,
  output logic                smp_tvalid,
  input  logic                smp_tready,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [CNT_W-1:0]    sample_cnt
);

  localparam int unsigned PopW = pop_width(DECIM);
  localparam int unsigned BitW = $clog2(DECIM);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [PopW-1:0]     pop_q, pop_d;
  logic [SAMPLE_W-1:0] tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                run_en;
  logic                bit_strobe;
  logic [SAMPLE_W-1:0] sample;

  assign run_en = (state_q == StRun);

  mic_pdm_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .enable     (run_en),
    .div        (div_q),
    .pdm_clk    (pdm_clk),
    .bit_strobe (bit_strobe)
  );

  // Final bit of the window is folded in directly; offset by DECIM/2 to centre on zero.
  assign sample = SAMPLE_W'(pop_q + PopW'(pdm_data)) - SAMPLE_W'(DECIM / 2);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= StIdle;
      div_q    <= '0;
      num_q    <= '0;
      bit_q    <= '0;
      pop_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      num_q    <= num_d;
      bit_q    <= bit_d;
      pop_q    <= pop_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    num_d    = num_q;
    bit_d    = bit_q;
    pop_d    = pop_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;

    if (tvalid_q && smp_tready) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d = StRun;
          div_d   = cfg_clk_div;
          num_d   = cfg_num_samples;
          bit_d   = '0;
          pop_d   = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (cfg_stop) begin
          state_d = StDrain;
        end else if (bit_strobe) begin
          if (bit_q == BitW'(DECIM - 1)) begin
            bit_d = '0;
            pop_d = '0;
            // Held and not accepted this cycle: drop the new sample.
            if (tvalid_q && !smp_tready) begin
              ovf_d = 1'b1;
            end else begin
              tdata_d  = sample;
              tvalid_d = 1'b1;
            end
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
            if ((num_q != '0) && (cnt_d == num_q)) begin
              state_d = StDrain;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            pop_d = pop_q + PopW'(pdm_data);
          end
        end
      end
      StDrain: begin
        if (!tvalid_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pdm_lrsel  = 1'b0;
  assign smp_tdata  = tdata_q;
  assign smp_tvalid = tvalid_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl with DECIM=8 and a 4-cycle PDM clock.
module tb_mic_capture_ctrl;

  logic        ACLK;
  logic        ARESETN;
  logic        cfg_start;
  logic        cfg_stop;
  logic [7:0]  cfg_clk_div;
  logic [15:0] cfg_num_samples;
  logic        pdm_clk;
  logic        pdm_lrsel;
  logic        pdm_data;
  logic [15:0] smp_tdata;
  logic        smp_tvalid;
  logic        smp_tready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] sample_cnt;

  logic        pdm_level;
  logic        alt_mode;
  logic        alt_bit = 1'b0;

  int unsigned n_cmp;
  int unsigned n_fail;
  int unsigned cyc;
  logic        pclk_prev;
  int unsigned rise_cyc[$];
  logic [15:0] acc_data[$];

  mic_capture_ctrl #(
    .DIV_W    (8),
    .DECIM    (8),
    .SAMPLE_W (16),
    .CNT_W    (16)
  ) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .cfg_start       (cfg_start),
    .cfg_stop        (cfg_stop),
    .cfg_clk_div     (cfg_clk_div),
    .cfg_num_samples (cfg_num_samples),
    .pdm_clk         (pdm_clk),
    .pdm_lrsel       (pdm_lrsel),
    .pdm_data        (pdm_data),
    .smp_tdata       (smp_tdata),
    .smp_tvalid      (smp_tvalid),
    .smp_tready      (smp_tready),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .sample_cnt      (sample_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  assign pdm_data = alt_mode ? alt_bit : pdm_level;
  always @(posedge pdm_clk) alt_bit <= ~alt_bit;

  // Record pdm_clk rises and accepted samples at the falling ACLK edge.
  initial pclk_prev = 1'b0;
  initial cyc = 0;
  always @(negedge ACLK) begin
    cyc = cyc + 1;
    if (pdm_clk === 1'b1 && pclk_prev !== 1'b1) rise_cyc.push_back(cyc);
    pclk_prev = pdm_clk;
    if (smp_tvalid === 1'b1 && smp_tready === 1'b1) acc_data.push_back(smp_tdata);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic start_cap(input logic [7:0] div, input logic [15:0] num);
    cfg_clk_div     = div;
    cfg_num_samples = num;
    cfg_start       = 1'b1;
    tick(1);
    cfg_start       = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop = 1'b1;
    tick(1);
    cfg_stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sample_cnt === target) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (smp_tvalid === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (pdm_clk !== 1'b0) begin n_fail++; $display("FAIL rst_pdm_clk: got %b want 0", pdm_clk); end
    n_cmp++; if (pdm_lrsel !== 1'b0) begin n_fail++; $display("FAIL rst_lrsel: got %b want 0", pdm_lrsel); end
    n_cmp++; if (smp_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", smp_tvalid); end
    n_cmp++; if (smp_tdata !== 16'h0000) begin n_fail++; $display("FAIL rst_tdata: got %h want 0000", smp_tdata); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", sample_cnt); end
  endtask

  task automatic test_basic();
    bit ok;
    int unsigned period;
    pdm_level = 1'b1; smp_tready = 1'b1;
    acc_data.delete(); rise_cyc.delete();
    start_cap(8'd1, 16'd3);
    wait_idle(400, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got %b want 1", ok); end
    n_cmp++; if (acc_data.size() != 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", acc_data.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (acc_data[i] !== 16'h0004) begin n_fail++; $display("FAIL basic_data%0d: got %h want 0004", i, acc_data[i]); end
    end
    period = (rise_cyc.size() >= 3) ? rise_cyc[2] - rise_cyc[1] : 0;
    n_cmp++; if (period != 4) begin n_fail++; $display("FAIL basic_period: got %0d want 4", period); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (sample_cnt !== 16'd3) begin n_fail++; $display("FAIL basic_cnt: got %0d want 3", sample_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", overflow); end
    n_cmp++; if (pdm_clk !== 1'b0) begin n_fail++; $display("FAIL basic_pclk_idle: got %b want 0", pdm_clk); end
  endtask

  task automatic test_patterns();
    bit ok;
    pdm_level = 1'b0;
    acc_data.delete();
    start_cap(8'd1, 16'd3);
    wait_idle(400, ok);
    n_cmp++; if (acc_data.size() != 3) begin n_fail++; $display("FAIL zero_count: got %0d want 3", acc_data.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (acc_data[i] !== 16'hFFFC) begin n_fail++; $display("FAIL zero_data%0d: got %h want fffc", i, acc_data[i]); end
    end
    alt_mode = 1'b1;
    acc_data.delete();
    start_cap(8'd1, 16'd3);
    wait_idle(400, ok);
    alt_mode = 1'b0;
    n_cmp++; if (acc_data.size() != 3) begin n_fail++; $display("FAIL alt_count: got %0d want 3", acc_data.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (acc_data[i] !== 16'h0000) begin n_fail++; $display("FAIL alt_data%0d: got %h want 0000", i, acc_data[i]); end
    end
  endtask

  task automatic test_stop();
    bit ok;
    pdm_level = 1'b1; smp_tready = 1'b1;
    acc_data.delete();
    start_cap(8'd1, 16'd0);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (acc_data.size() >= 5) begin ok = 1'b1; break; end
      tick(1);
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stop_timeout: got %b want 1", ok); end
    tick(8);
    pulse_stop();
    n_cmp++; if (pdm_clk !== 1'b0) begin n_fail++; $display("FAIL stop_pclk: got %b want 0", pdm_clk); end
    tick(2);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL stop_done: got %b want 1", done); end
    n_cmp++; if (sample_cnt !== 16'd5) begin n_fail++; $display("FAIL stop_cnt: got %0d want 5", sample_cnt); end
    n_cmp++; if (acc_data.size() != 5) begin n_fail++; $display("FAIL stop_emitted: got %0d want 5", acc_data.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    pdm_level = 1'b1; smp_tready = 1'b0;
    acc_data.delete();
    start_cap(8'd1, 16'd4);
    wait_valid(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", ok); end
    pdm_level = 1'b0;
    n_cmp++; if (smp_tdata !== 16'h0004) begin n_fail++; $display("FAIL bp_first_data: got %h want 0004", smp_tdata); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_early: got %b want 0", overflow); end
    wait_cnt(16'd2, 100, ok);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_set: got %b want 1", overflow); end
    n_cmp++; if (smp_tdata !== 16'h0004) begin n_fail++; $display("FAIL bp_held_data: got %h want 0004", smp_tdata); end
    wait_cnt(16'd4, 200, ok);
    tick(3);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_drain_busy: got %b want 1", busy); end
    n_cmp++; if (smp_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid: got %b want 1", smp_tvalid); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL bp_drain_done: got %b want 0", done); end
    n_cmp++; if (pdm_clk !== 1'b0) begin n_fail++; $display("FAIL bp_drain_pclk: got %b want 0", pdm_clk); end
    smp_tready = 1'b1;
    wait_idle(10, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b want 1", ok); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", done); end
    n_cmp++; if (acc_data.size() != 1) begin n_fail++; $display("FAIL bp_accepted: got %0d want 1", acc_data.size()); end
    n_cmp++; if (acc_data[0] !== 16'h0004) begin n_fail++; $display("FAIL bp_accepted_data: got %h want 0004", acc_data[0]); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky: got %b want 1", overflow); end
    n_cmp++; if (sample_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_cnt: got %0d want 4", sample_cnt); end
  endtask

  task automatic test_start_stop();
    bit ok;
    pdm_level = 1'b1; smp_tready = 1'b1;
    cfg_clk_div = 8'd1; cfg_num_samples = 16'd0;
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick(1);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ss_start_wins: got %b want 1", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ss_ovf_cleared: got %b want 0", overflow); end
    wait_cnt(16'd2, 200, ok);
    tick(4);
    cfg_num_samples = 16'd3;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    n_cmp++; if (sample_cnt !== 16'd2) begin n_fail++; $display("FAIL ss_no_clear: got %0d want 2", sample_cnt); end
    wait_cnt(16'd3, 200, ok);
    tick(5);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ss_no_relatch: got %b want 1", busy); end
    pulse_stop();
    wait_idle(10, ok);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL ss_done: got %b want 1", done); end
    n_cmp++; if (sample_cnt !== 16'd3) begin n_fail++; $display("FAIL ss_cnt: got %0d want 3", sample_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int unsigned n_valid;
    pdm_level = 1'b1; smp_tready = 1'b1;
    start_cap(8'd1, 16'd0);
    wait_cnt(16'd1, 100, ok);
    for (int i = 0; i < 8; i++) begin
      if (pdm_clk === 1'b1) break;
      tick(1);
    end
    #2;
    ARESETN = 1'b0;
    #1;
    n_cmp++; if (pdm_clk !== 1'b0) begin n_fail++; $display("FAIL ar_pclk: got %b want 0", pdm_clk); end
    n_cmp++; if (smp_tvalid !== 1'b0) begin n_fail++; $display("FAIL ar_tvalid: got %b want 0", smp_tvalid); end
    n_cmp++; if (smp_tdata !== 16'h0000) begin n_fail++; $display("FAIL ar_tdata: got %h want 0000", smp_tdata); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ar_ovf: got %b want 0", overflow); end
    n_cmp++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", sample_cnt); end
    tick(1);
    ARESETN = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 100; i++) begin
      if (smp_tvalid !== 1'b0) n_valid++;
      tick(1);
    end
    n_cmp++; if (n_valid != 0) begin n_fail++; $display("FAIL ar_no_valid: got %0d want 0", n_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_stays_idle: got %b want 0", busy); end
    n_cmp++; if (pdm_clk !== 1'b0) begin n_fail++; $display("FAIL ar_pclk_idle: got %b want 0", pdm_clk); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    ARESETN = 1'b0;
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    cfg_clk_div = 8'd0;
    cfg_num_samples = 16'd0;
    smp_tready = 1'b1;
    pdm_level = 1'b1;
    alt_mode = 1'b0;
    #2;
    test_reset();
    tick(2);
    ARESETN = 1'b1;
    tick(1);
    test_basic();
    test_patterns();
    test_stop();
    test_backpressure();
    test_start_stop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
